// File: rtl/mips_defines.sv
// mips_defines: widths, enables, opcodes and the inter-stage
// bundles shared by the OpenMIPS core and the minimal SOPC.
package mips_defines;
  localparam int INST_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;
  localparam int INST_ADDR_W_DEF = 10;
  localparam int DATA_ADDR_W_DEF = 10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_OR      = 6'h25;

  typedef enum logic [2:0] {
    M_NONE, M_LW, M_LBU, M_SW, M_SB
  } mop_e;

  typedef enum logic [1:0] {
    A_ADD, A_SUB, A_OR
  } aop_e;

  typedef struct packed {
    mop_e              mop;
    aop_e              aop;
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] sd;
  } id_ex_t;

  typedef struct packed {
    mop_e              mop;
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sd;
  } ex_mem_t;

  typedef struct packed {
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] res;
  } mem_wb_t;
endpackage

// File: rtl/data_ram.sv
// data_ram: four byte banks, per-lane write on sel, comb read.
// Ports: clk, ce, we, sel[3:0], addr, data_i in; data_o out.
module data_ram
  import mips_defines::*;
#(
  parameter int ADDR_W = DATA_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);
  logic [7:0] bank0 [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  logic [7:0] bank1 [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  logic [7:0] bank2 [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  logic [7:0] bank3 [0:(1<<ADDR_W)-1] = '{default: 8'h00};
  logic [ADDR_W-1:0] w_idx;
  logic w_unused_addr;

  assign w_idx = addr[ADDR_W+1:2];
  assign w_unused_addr = ^{addr[DATA_W-1:ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (ce && we) begin
      if (sel[0]) bank0[w_idx] <= data_i[7:0];
      if (sel[1]) bank1[w_idx] <= data_i[15:8];
      if (sel[2]) bank2[w_idx] <= data_i[23:16];
      if (sel[3]) bank3[w_idx] <= data_i[31:24];
    end
  end

  assign data_o = (ce && !we) ?
    {bank3[w_idx], bank2[w_idx], bank1[w_idx], bank0[w_idx]} : '0;
endmodule

// File: rtl/inst_rom.sv
// inst_rom: combinational instruction ROM, word-indexed, wraps.
// Ports: ce, addr (byte address) in; inst out (0 when ce=0).
module inst_rom
  import mips_defines::*;
#(
  parameter int ADDR_W = INST_ADDR_W_DEF
) (
  input  logic              ce,
  input  logic [DATA_W-1:0] addr,
  output logic [INST_W-1:0] inst
);
  // Image is written into inst_mem by the simulation environment.
  logic [INST_W-1:0] inst_mem [0:(1<<ADDR_W)-1] = '{default: '0};
  logic w_unused_addr;

  assign w_unused_addr = ^{addr[DATA_W-1:ADDR_W+2], addr[1:0]};
  assign inst = ce ? inst_mem[addr[ADDR_W+1:2]] : '0;
endmodule

// File: rtl/openmips.sv
// openmips: five-stage core (ori/lui/addu/subu/or/lw/lbu/sw/sb),
// forwarding to ID, one-cycle load-use stall; rom_*/ram_* buses.
module regfile
  import mips_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs <= '{default: '0};
    else if (we && waddr != '0) regs[waddr] <= wdata;
  end

  // Write-through so WB and ID can share a cycle.
  assign rdata1 = (we && waddr == raddr1 && raddr1 != '0) ?
    wdata : regs[raddr1];
  assign rdata2 = (we && waddr == raddr2 && raddr2 != '0) ?
    wdata : regs[raddr2];
endmodule

module openmips
  import mips_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic              ram_ce_o
);
  logic [DATA_W-1:0] r_pc;
  logic              r_ce;
  logic [INST_W-1:0] r_ifid;
  id_ex_t  r_idex, w_idex;
  ex_mem_t r_exmem, w_exmem;
  mem_wb_t r_memwb, w_memwb;
  logic [5:0] w_op, w_fn;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [DATA_W-1:0] w_rf1, w_rf2, w_rs_v, w_rt_v;
  logic w_use_rs, w_use_rt, w_stall, w_ld, w_st;
  logic [7:0] w_lbyte;

  assign rom_addr_o = r_pc;
  assign rom_ce_o   = r_ce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce <= DIS;
      r_pc <= '0;
    end else begin
      r_ce <= EN;
      if (r_ce && !w_stall) r_pc <= r_pc + 32'd4;
    end
  end

  assign w_op  = r_ifid[31:26];
  assign w_rs  = r_ifid[25:21];
  assign w_rt  = r_ifid[20:16];
  assign w_rd  = r_ifid[15:11];
  assign w_fn  = r_ifid[5:0];
  assign w_imm = r_ifid[15:0];

  regfile regfile1 (
    .clk(clk), .rst(rst),
    .we(r_memwb.wreg), .waddr(r_memwb.waddr),
    .wdata(r_memwb.res),
    .raddr1(w_rs), .rdata1(w_rf1),
    .raddr2(w_rt), .rdata2(w_rf2)
  );

  // Youngest producer wins: EX, then MEM, then the regfile.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] rf,
    input ex_mem_t e, input mem_wb_t m);
    if (a == '0) return '0;
    if (e.wreg && e.waddr == a) return e.res;
    if (m.wreg && m.waddr == a) return m.res;
    return rf;
  endfunction

  assign w_rs_v = fwd(w_rs, w_rf1, w_exmem, w_memwb);
  assign w_rt_v = fwd(w_rt, w_rf2, w_exmem, w_memwb);

  always_comb begin
    w_idex       = '0;
    w_use_rs     = DIS;
    w_use_rt     = DIS;
    w_idex.a     = w_rs_v;
    w_idex.b     = {{16{w_imm[15]}}, w_imm};
    w_idex.sd    = w_rt_v;
    w_idex.waddr = w_rt;
    unique case (w_op)
      OP_SPECIAL: begin
        w_use_rs = EN; w_use_rt = EN;
        w_idex.b = w_rt_v;
        w_idex.waddr = w_rd;
        w_idex.wreg = EN;
        unique case (w_fn)
          FN_ADDU: w_idex.aop = A_ADD;
          FN_SUBU: w_idex.aop = A_SUB;
          FN_OR:   w_idex.aop = A_OR;
          default: w_idex.wreg = DIS;
        endcase
      end
      OP_ORI: begin
        w_use_rs = EN;
        w_idex.b = {16'h0, w_imm};
        w_idex.aop = A_OR; w_idex.wreg = EN;
      end
      OP_LUI: begin
        w_idex.a = '0;
        w_idex.b = {w_imm, 16'h0};
        w_idex.aop = A_OR; w_idex.wreg = EN;
      end
      OP_LW: begin
        w_use_rs = EN; w_idex.mop = M_LW; w_idex.wreg = EN;
      end
      OP_LBU: begin
        w_use_rs = EN; w_idex.mop = M_LBU; w_idex.wreg = EN;
      end
      OP_SW: begin
        w_use_rs = EN; w_use_rt = EN; w_idex.mop = M_SW;
      end
      OP_SB: begin
        w_use_rs = EN; w_use_rt = EN; w_idex.mop = M_SB;
      end
      default: ;
    endcase
  end

  // Load data only exists in MEM, so a consumer right behind waits.
  assign w_stall = (r_idex.mop inside {M_LW, M_LBU}) &&
    r_idex.waddr != '0 &&
    ((w_use_rs && r_idex.waddr == w_rs) ||
     (w_use_rt && r_idex.waddr == w_rt));

  always_comb begin
    w_exmem.mop   = r_idex.mop;
    w_exmem.wreg  = r_idex.wreg;
    w_exmem.waddr = r_idex.waddr;
    w_exmem.sd    = r_idex.sd;
    unique case (r_idex.aop)
      A_SUB:   w_exmem.res = r_idex.a - r_idex.b;
      A_OR:    w_exmem.res = r_idex.a | r_idex.b;
      default: w_exmem.res = r_idex.a + r_idex.b;
    endcase
  end

  assign w_ld = r_exmem.mop inside {M_LW, M_LBU};
  assign w_st = r_exmem.mop inside {M_SW, M_SB};
  assign ram_ce_o   = w_ld | w_st;
  assign ram_we_o   = w_st;
  assign ram_addr_o = r_exmem.res;
  assign ram_sel_o  = (r_exmem.mop == M_SB) ?
    4'b0001 << r_exmem.res[1:0] : 4'b1111;
  assign ram_data_o = (r_exmem.mop == M_SB) ?
    {4{r_exmem.sd[7:0]}} : r_exmem.sd;
  assign w_lbyte = 8'(ram_data_i >> {r_exmem.res[1:0], 3'b000});

  always_comb begin
    w_memwb.wreg  = r_exmem.wreg;
    w_memwb.waddr = r_exmem.waddr;
    w_memwb.res   = r_exmem.res;
    if (r_exmem.mop == M_LW) w_memwb.res = ram_data_i;
    else if (r_exmem.mop == M_LBU) w_memwb.res = {24'h0, w_lbyte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid  <= '0;
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      if (!w_stall) r_ifid <= rom_data_i;
      r_idex  <= w_stall ? '0 : w_idex;
      r_exmem <= w_exmem;
      r_memwb <= w_memwb;
    end
  end
endmodule

// File: rtl/mips_min_sopc.sv
// mips_min_sopc: OpenMIPS core + instruction ROM + data RAM.
// Ports: clk, rst (async, active-high); no other I/O.
module mips_min_sopc
  import mips_defines::*;
#(
  parameter int INST_ADDR_W = INST_ADDR_W_DEF,
  parameter int DATA_ADDR_W = DATA_ADDR_W_DEF
) (
  input logic clk,
  input logic rst
);
  logic [DATA_W-1:0] w_rom_addr;
  logic              w_rom_ce;
  logic [INST_W-1:0] w_inst;
  logic [DATA_W-1:0] w_ram_addr, w_ram_wdata, w_ram_rdata;
  logic              w_ram_we, w_ram_ce;
  logic [3:0]        w_ram_sel;

  openmips openmips0 (
    .clk(clk), .rst(rst),
    .rom_data_i(w_inst), .rom_addr_o(w_rom_addr),
    .rom_ce_o(w_rom_ce),
    .ram_data_i(w_ram_rdata), .ram_addr_o(w_ram_addr),
    .ram_data_o(w_ram_wdata), .ram_we_o(w_ram_we),
    .ram_sel_o(w_ram_sel), .ram_ce_o(w_ram_ce)
  );

  inst_rom #(.ADDR_W(INST_ADDR_W)) inst_rom0 (
    .ce(w_rom_ce), .addr(w_rom_addr), .inst(w_inst)
  );

  data_ram #(.ADDR_W(DATA_ADDR_W)) data_ram0 (
    .clk(clk), .ce(w_ram_ce), .we(w_ram_we),
    .sel(w_ram_sel), .addr(w_ram_addr),
    .data_i(w_ram_wdata), .data_o(w_ram_rdata)
  );
endmodule

// File: tb/tb_mips_min_sopc.sv
// tb_mips_min_sopc: directed + random programs checked against
// an instruction-level model of registers and byte memory.
module tb_mips_min_sopc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_min_sopc #(.INST_ADDR_W(10), .DATA_ADDR_W(10)) dut (
    .clk(clk), .rst(rst)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] prog [64];
  int prog_n;
  logic [7:0] m_mem [4096];
  logic [31:0] m_reg [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] dut_word(input int i);
    return {dut.data_ram0.bank3[i], dut.data_ram0.bank2[i],
            dut.data_ram0.bank1[i], dut.data_ram0.bank0[i]};
  endfunction

  function automatic logic [31:0] m_word(input int i);
    return {m_mem[4*i+3], m_mem[4*i+2], m_mem[4*i+1], m_mem[4*i]};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++)
      dut.inst_rom0.inst_mem[i] = (i < prog_n) ? prog[i] : 32'h0;
  endtask

  // Sequential ISA semantics; memory is a flat 4 KiB byte array.
  task automatic model_run();
    logic [31:0] w, sx, a;
    logic [4:0] rs, rt, rd;
    logic [11:0] ba, wa;
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    for (int k = 0; k < prog_n; k++) begin
      w  = prog[k];
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      sx = {{16{w[15]}}, w[15:0]};
      a  = m_reg[rs] + sx;
      ba = a[11:0];
      wa = {a[11:2], 2'b00};
      case (w[31:26])
        6'h00: case (w[5:0])
          6'h21: m_reg[rd] = m_reg[rs] + m_reg[rt];
          6'h23: m_reg[rd] = m_reg[rs] - m_reg[rt];
          6'h25: m_reg[rd] = m_reg[rs] | m_reg[rt];
          default: ;
        endcase
        6'h0D: m_reg[rt] = m_reg[rs] | {16'h0, w[15:0]};
        6'h0F: m_reg[rt] = {w[15:0], 16'h0};
        6'h23: m_reg[rt] = {m_mem[wa+3], m_mem[wa+2],
                            m_mem[wa+1], m_mem[wa]};
        6'h24: m_reg[rt] = {24'h0, m_mem[ba]};
        6'h2B: begin
          m_mem[wa]   = m_reg[rt][7:0];
          m_mem[wa+1] = m_reg[rt][15:8];
          m_mem[wa+2] = m_reg[rt][23:16];
          m_mem[wa+3] = m_reg[rt][31:24];
        end
        6'h28: m_mem[ba] = m_reg[rt][7:0];
        default: ;
      endcase
      m_reg[0] = '0;
    end
  endtask

  task automatic compare_state(input string tag);
    for (int r = 1; r < 32; r++)
      chk($sformatf("%s_r%0d", tag, r),
          dut.openmips0.regfile1.regs[r], m_reg[r]);
    for (int i = 0; i < 1024; i++)
      chk($sformatf("%s_m%0d", tag, i), dut_word(i), m_word(i));
  endtask

  function automatic logic [15:0] rnd_woff();
    if ($urandom_range(0, 3) == 0)
      return 16'hFFFC - 16'(4 * $urandom_range(0, 3));
    return 16'(4 * $urandom_range(0, 15));
  endfunction

  logic [31:0] prev_pc;
  int holds;

  initial begin
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;

    prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h1234);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
    prog[2] = enc_i(6'h0D, 5'd0, 5'd2, 16'h00AB);
    prog[3] = enc_i(6'h28, 5'd0, 5'd2, 16'h0001);
    prog[4] = enc_i(6'h23, 5'd0, 5'd1, 16'h0008);
    prog[5] = enc_r(5'd1, 5'd1, 5'd3, 6'h21);
    prog[6] = enc_i(6'h23, 5'd0, 5'd5, 16'h0004);
    prog[7] = enc_i(6'h23, 5'd0, 5'd6, 16'h0008);
    prog[8] = enc_i(6'h0D, 5'd0, 5'd1, 16'h89AB);
    prog_n = 9;
    load_prog();

    repeat (10) begin
      @(posedge clk); #1;
      chk("rst_ce", 32'(dut.w_rom_ce), 32'd0);
      chk("rst_pc", dut.w_rom_addr, 32'd0);
      chk("rst_w2", dut_word(2), 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    model_run();

    holds = 0;
    prev_pc = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk("rel_ce", 32'(dut.w_rom_ce), 32'd1);
        chk("rel_pc0", dut.w_rom_addr, 32'd0);
      end
      if (n == 2) chk("rel_pc4", dut.w_rom_addr, 32'd4);
      if (n == 7 || n == 8)
        chk($sformatf("stall_pc_c%0d", n), dut.w_rom_addr, 32'd24);
      if (n == 11)
        chk("addu_early", dut.openmips0.regfile1.regs[3], 32'd0);
      if (n == 12)
        chk("addu_late", dut.openmips0.regfile1.regs[3], 32'h2468);
      if (n > 1 && dut.w_rom_ce && dut.w_rom_addr == prev_pc)
        holds++;
      prev_pc = dut.w_rom_addr;
    end
    chk("stall_holds", 32'(holds), 32'd1);
    chk("r1_ori", dut.openmips0.regfile1.regs[1], 32'h000089AB);
    chk("r2_ori", dut.openmips0.regfile1.regs[2], 32'h000000AB);
    chk("r5_lw0", dut.openmips0.regfile1.regs[5], 32'h0);
    chk("r6_lw8", dut.openmips0.regfile1.regs[6], 32'h00001234);
    chk("w2", dut_word(2), 32'h00001234);
    chk("b3_2", 32'(dut.data_ram0.bank3[2]), 32'h00);
    chk("b0_2", 32'(dut.data_ram0.bank0[2]), 32'h34);
    chk("b1_0", 32'(dut.data_ram0.bank1[0]), 32'hAB);
    chk("w0", dut_word(0), 32'h0000AB00);
    compare_state("dir");

    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 8) chk("mid_pc", dut.w_rom_addr, 32'd24);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_pc", dut.w_rom_addr, 32'd0);
    chk("async_ce", 32'(dut.w_rom_ce), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_w2", dut_word(2), 32'h00001234);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_pc0", dut.w_rom_addr, 32'd0);
    chk("restart_ce", 32'(dut.w_rom_ce), 32'd1);
    @(posedge clk); #1;
    chk("restart_pc4", dut.w_rom_addr, 32'd4);
    repeat (40) @(posedge clk);
    #1;
    compare_state("restart");

    for (int t = 0; t < 8; t++) begin
      @(negedge clk) rst = 1'b1;
      prog_n = 24;
      for (int k = 0; k < prog_n; k++) begin
        logic [4:0] rs, rt, rd;
        logic [15:0] imm, boff;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        boff = 16'($urandom_range(0, 3));
        case ($urandom_range(0, 8))
          0: prog[k] = enc_i(6'h0D, rs, rt, imm);
          1: prog[k] = enc_i(6'h0F, 5'd0, rt, imm);
          2: prog[k] = enc_r(rs, rt, rd, 6'h21);
          3: prog[k] = enc_r(rs, rt, rd, 6'h23);
          4: prog[k] = enc_r(rs, rt, rd, 6'h25);
          5: prog[k] = enc_i(6'h23, 5'd0, rt, rnd_woff());
          6: prog[k] = enc_i(6'h24, 5'd0, rt, rnd_woff() + boff);
          7: prog[k] = enc_i(6'h2B, 5'd0, rt, rnd_woff());
          default: prog[k] = enc_i(6'h28, 5'd0, rt, rnd_woff() + boff);
        endcase
      end
      load_prog();
      model_run();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      compare_state($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
